imem_responder: RTL
===================

# imem_responder

Responder end of the instruction-fetch interface: accepts one fetch request at a time from the fetch stage, models a wait-state instruction memory, and returns the instruction word with a valid/ready handshake. Redirects (taken branch) abort an in-flight fetch without producing a response. Sits between the fetch stage and the instruction storage, replacing the zero-latency lookup with a cycle-accurate, stall-producing memory.

## Interface
- ADDR_WIDTH, 32: byte-address width.
- DEPTH_WORDS, 1024: number of 32-bit words stored.
- LATENCY, 2: wait cycles between accept and response; legal range 0–15.
- INIT_FILE, "program.hex": hex image loaded into storage at elaboration.

Clocking is one clock. Reset is synchronous and active-low.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept; high only in IDLE with rst high and req_abort low.
- req_addr  in  ADDR_WIDTH  byte address of the requested instruction.
- req_abort  in  1  redirect; kills any in-flight fetch.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes response.
- resp_addr  out  ADDR_WIDTH  address of the returned word.
- resp_instr  out  32  instruction word.
- resp_err  out  1  misaligned or out-of-range address.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: accept when req_valid && req_ready. Latch the address and set the counter to LATENCY. Go to WAIT, or to RESP if LATENCY==0.
- WAIT: decrement the counter each cycle. When the counter reaches 0, register the array read into resp_* and go to RESP.
- RESP: resp_valid=1. resp_* are held stable until resp_valid && resp_ready. On that handshake, go to IDLE; a new request can be accepted the following cycle.
- Error: the address is in error if req_addr[1:0]!=0 or req_addr[ADDR_WIDTH-1:2] >= DEPTH_WORDS. An error response has resp_err=1 and resp_instr=NOP_INSTR (32'h00000013), with the same latency as a normal response.
- Abort has priority over everything:
  - In WAIT or RESP, go to IDLE next cycle with resp_valid=0 and no response delivered, even if resp_ready is high that cycle.
  - In IDLE, it blocks acceptance.
- Only one request is ever outstanding; there is no queueing.

## Timing
- Reset values: state IDLE, req_ready=0 while rst low, resp_valid=0, resp_addr=0, resp_instr=0, resp_err=0, counter=0, prefetch buffer invalid.
- Rst asserted mid-fetch discards the fetch; the state is IDLE on the first cycle after reset is released.
- Accept in cycle 0 → resp_valid first high in cycle LATENCY+1.
- Back-to-back throughput is one request per LATENCY+2 cycles, assuming resp_ready is held high.
- req_ready depends combinationally on state and req_abort only. It has no path from req_valid.
- resp_valid depends only on state and is registered.

## Configuration
- IMEM_PREFETCH_EN defined:
  - A one-entry next-line buffer holds {addr, instr, valid}.
  - On every delivered non-error response for address A, the buffer is loaded with the word at A+4 and marked valid (if A+4 is in range).
  - A request whose address matches a valid buffer goes directly to RESP, with resp_valid in cycle 1 regardless of LATENCY.
  - req_abort and rst invalidate the buffer.
- IMEM_PREFETCH_EN undefined: no buffer exists, and every request takes the full LATENCY path.

## Structure
- imem_pkg holds:
  - NOP_INSTR.
  - The state enum (IDLE/WAIT/RESP).
  - The counter width constant (4 bits).
- Sub-module imem_array: word storage of DEPTH_WORDS×32 with combinational read by word index, initialised from INIT_FILE. The responder instantiates it once.
  - With IMEM_PREFETCH_EN, the array has a second read port for A+4.

## Test plan
- LATENCY=2, INIT_FILE word[1]=32'h00500093; request addr 0x4 in cycle 0 with resp_ready=1 → resp_valid in cycle 3, resp_instr=0x00500093, resp_err=0; req_ready high again in cycle 4.
- resp_ready held low 5 cycles after resp_valid → resp_addr, resp_instr and resp_valid stable for all 5 cycles; handshake completes when resp_ready rises.
- Request addr 0x6, then addr 0x1000 with DEPTH_WORDS=1024 → each gives resp_err=1 and resp_instr=0x00000013 after LATENCY+1 cycles.
- Request 0x8, assert req_abort in cycle 2 → no resp_valid at any point; req_ready high in cycle 3. Repeat with abort in the RESP cycle while resp_ready=1 → no delivery counted.
- rst driven low during WAIT → all outputs return to reset values on the next edge; a fresh request after release completes normally.
- IMEM_PREFETCH_EN, LATENCY=4: fetch 0x10 and consume it, then request 0x14 → resp_valid in cycle 1 after accept. A following request to 0x40 takes 5 cycles.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, FSM state encoding and the built-in program image
// for the instruction-memory responder.
package imem_pkg;

    // Canonical RISC-V no-op (addi x0, x0, 0); returned on erroneous fetches.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Width of the wait-state counter; covers LATENCY values 0..15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    // Contents of the "program.hex" image: word i is "addi x1, x0, 5*i".
    // The 12-bit immediate wraps, but 5 is odd, so every word of a
    // 1024-word image is distinct.
    function automatic logic [31:0] imem_image_word(input int unsigned idx);
        logic [31:0] imm;
        imm = idx * 32'd5;
        return (imm << 20) | 32'h0000_0093;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch-stage <-> instruction-memory handshake bundle.
// The master is the fetch stage; the slave is the imem_responder.
interface imem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_abort;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [31:0]           resp_instr;
    logic                  resp_err;

    modport master (
        output req_valid, req_addr, req_abort, resp_ready,
        input  req_ready, resp_valid, resp_addr, resp_instr, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_abort, resp_ready,
        output req_ready, resp_valid, resp_addr, resp_instr, resp_err
    );
endinterface

// File: rtl/imem_array.sv
// imem_array: DEPTH_WORDS x 32 instruction storage with combinational read by
// word index. Indices at or beyond DEPTH_WORDS read back as NOP_INSTR.
// With IMEM_PREFETCH_EN defined a second read port serves the next-line buffer.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 11,
    parameter string       INIT_FILE   = "program.hex"
) (
    input  logic [IDX_W-1:0] rd_idx_a_i,
    output logic [31:0]      rd_data_a_o
`ifdef IMEM_PREFETCH_EN
    ,
    input  logic [IDX_W-1:0] rd_idx_b_i,
    output logic [31:0]      rd_data_b_o
`endif
);

    // Only the "program.hex" image is built in; any other name gives an all-NOP store.
    localparam bit USE_IMAGE = (INIT_FILE == "program.hex");
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    genvar gi;
    for (gi = 0; gi < int'(DEPTH_WORDS); gi++) begin : g_word
        assign mem[gi] = USE_IMAGE ? imem_image_word(gi) : NOP_INSTR;
    end

    assign rd_data_a_o = (rd_idx_a_i < DEPTH_I) ? mem[rd_idx_a_i[IDX_W-2:0]] : NOP_INSTR;

`ifdef IMEM_PREFETCH_EN
    assign rd_data_b_o = (rd_idx_b_i < DEPTH_I) ? mem[rd_idx_b_i[IDX_W-2:0]] : NOP_INSTR;
`endif

endmodule

// File: rtl/imem_responder.sv
// imem_responder: responder end of the instruction-fetch interface. Accepts one
// request at a time, waits LATENCY cycles, then presents the word until it is
// consumed. req_abort kills any in-flight fetch; rst is synchronous, active-low.
// Optional feature macro: IMEM_PREFETCH_EN (one-entry next-line buffer).
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter string       INIT_FILE   = "program.hex"
) (
    input  logic             clk,
    input  logic             rst,
    imem_responder_if.slave  bus
);

    localparam int unsigned           IDX_W   = $clog2(DEPTH_WORDS) + 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]      LAT_CNT = CNT_W'(LATENCY);

    localparam logic [1:0] ST_IDLE = IMEM_IDLE;
    localparam logic [1:0] ST_WAIT = IMEM_WAIT;
    localparam logic [1:0] ST_RESP = IMEM_RESP;

    // Misaligned or beyond the last stored word.
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[ADDR_WIDTH-1:2]} >= DEPTH_A);
    endfunction

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           instr_q, instr_d;
    logic                  err_q, err_d;

    logic                  req_ready_w;
    logic                  accept_w;
    logic                  req_bad_w;
    logic                  held_bad_w;
    logic [IDX_W-1:0]      rd_idx_a;
    logic [31:0]           rd_data_a;

`ifdef IMEM_PREFETCH_EN
    logic [ADDR_WIDTH-1:0] pf_addr_q, pf_addr_d;
    logic [31:0]           pf_instr_q, pf_instr_d;
    logic                  pf_valid_q, pf_valid_d;
    logic                  pf_hit_w;
    logic                  next_in_range_w;
    logic [IDX_W-1:0]      rd_idx_b;
    logic [31:0]           rd_data_b;
`endif

    assign req_ready_w = (state_q == ST_IDLE) && rst && !bus.req_abort;
    assign accept_w    = bus.req_valid && req_ready_w;
    assign req_bad_w   = addr_bad(bus.req_addr);
    assign held_bad_w  = addr_bad(addr_q);

    // In IDLE the incoming address is looked up (zero-latency case); otherwise the held one.
    assign rd_idx_a = (state_q == ST_IDLE) ? bus.req_addr[IDX_W+1:2] : addr_q[IDX_W+1:2];

`ifdef IMEM_PREFETCH_EN
    assign pf_hit_w        = pf_valid_q && (pf_addr_q == bus.req_addr);
    assign rd_idx_b        = addr_q[IDX_W+1:2] + IDX_W'(1);
    assign next_in_range_w = ({2'b00, addr_q[ADDR_WIDTH-1:2]} + ADDR_WIDTH'(1)) < DEPTH_A;
`endif

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .rd_idx_a_i  (rd_idx_a),
        .rd_data_a_o (rd_data_a)
`ifdef IMEM_PREFETCH_EN
        ,
        .rd_idx_b_i  (rd_idx_b),
        .rd_data_b_o (rd_data_b)
`endif
    );

    // Next-state logic: accept, count wait states, hold the response, abort overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
`ifdef IMEM_PREFETCH_EN
        pf_addr_d  = pf_addr_q;
        pf_instr_d = pf_instr_q;
        pf_valid_d = pf_valid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    addr_d  = bus.req_addr;
                    cnt_d   = LAT_CNT;
                    state_d = ST_WAIT;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        err_d   = req_bad_w;
                        instr_d = req_bad_w ? NOP_INSTR : rd_data_a;
                    end
`ifdef IMEM_PREFETCH_EN
                    // A buffered next line skips the wait states entirely.
                    if (pf_hit_w) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        instr_d = pf_instr_q;
                    end
`endif
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    err_d   = held_bad_w;
                    instr_d = held_bad_w ? NOP_INSTR : rd_data_a;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
`ifdef IMEM_PREFETCH_EN
                    // A delivered good word primes the buffer with the following word.
                    if (!err_q) begin
                        pf_valid_d = next_in_range_w;
                        pf_addr_d  = addr_q + ADDR_WIDTH'(4);
                        pf_instr_d = rd_data_b;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.req_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
`ifdef IMEM_PREFETCH_EN
            pf_valid_d = 1'b0;
`endif
        end
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
`ifdef IMEM_PREFETCH_EN
            pf_addr_q  <= '0;
            pf_instr_q <= '0;
            pf_valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
`ifdef IMEM_PREFETCH_EN
            pf_addr_q  <= pf_addr_d;
            pf_instr_q <= pf_instr_d;
            pf_valid_q <= pf_valid_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_addr  = addr_q;
    assign bus.resp_instr = instr_q;
    assign bus.resp_err   = err_q;

endmodule
